// File: rtl/seq_arithmetic_unit.sv
// seq_arithmetic_unit
//   Registered arithmetic unit. Add, subtract and arithmetic shift right
//   complete in one cycle; unsigned multiply runs as a WIDTH-step shift-add.
//   Results and flags are written together and held until the next result.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   in_valid/in_ready request handshake (ready only in IDLE)
//   a, b, op          operands and opcode (0 add, 1 sub, 2 asr, 3 mul)
//   out_valid         one-cycle pulse when out/flags are updated
//   out, cout, zero, neg, ovf   result and flags
//
// state | meaning
// IDLE  | accepting requests, single-cycle ops complete here
// MUL   | shift-add multiply in progress, requests ignored
module seq_arithmetic_unit #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW:0]       cnt;

  logic               res_load;
  logic [WIDTH-1:0]   res_val;
  logic               res_c;
  logic               res_o;
  logic               mul_start;

  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   sh_tmp;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE);
  assign sh       = b[SHW-1:0];

  // Right-shifting accumulator: the running partial sum lives in the upper
  // half; each step adds the multiplicand there and shifts everything right.
  assign addend   = mplier[0] ? mcand : '0;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {mul_sum, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    res_load   = 1'b0;
    res_val    = '0;
    res_c      = 1'b0;
    res_o      = 1'b0;
    mul_start  = 1'b0;
    sh_tmp     = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          case (op)
            2'd0: begin
              res_load         = 1'b1;
              {res_c, res_val} = {1'b0, a} + {1'b0, b};
              res_o = (a[WIDTH-1] == b[WIDTH-1]) && (res_val[WIDTH-1] != a[WIDTH-1]);
            end
            2'd1: begin
              res_load         = 1'b1;
              {res_c, res_val} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
              res_o = (a[WIDTH-1] != b[WIDTH-1]) && (res_val[WIDTH-1] != a[WIDTH-1]);
            end
            2'd2: begin
              res_load = 1'b1;
              res_val  = WIDTH'($signed(a) >>> sh);
              // Last bit shifted out is a[sh-1]; none when the amount is 0.
              if (sh != '0) begin
                sh_tmp = a >> (sh - 1'b1);
                res_c  = sh_tmp[0];
              end
            end
            default: begin
              mul_start  = 1'b1;
              state_next = MUL;
            end
          endcase
        end
      end
      MUL: begin
        if (cnt == (SHW+1)'(1)) begin
          res_load   = 1'b1;
          res_val    = acc_next[WIDTH-1:0];
          res_o      = |acc_next[2*WIDTH-1:WIDTH];
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= res_load;
      if (res_load) begin
        out  <= res_val;
        cout <= res_c;
        zero <= (res_val == '0);
        neg  <= res_val[WIDTH-1];
        ovf  <= res_o;
      end
      if (mul_start) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= (SHW+1)'(WIDTH);
      end else if (state == MUL) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        cnt    <= cnt - (SHW+1)'(1);
      end
    end
  end

endmodule

// File: doc/seq_arithmetic_unit.md
# seq_arithmetic_unit

Parametrised, registered arithmetic unit: add, subtract and arithmetic right shift in one cycle, plus an unsigned shift-add multiplier that runs for WIDTH cycles. A valid/ready input handshake and registered result flags let it sit between a sequential controller and a register file. It replaces the purely combinational arithmetic unit wherever results must be registered or multiplication is needed.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 2)
- SHW, $clog2(WIDTH), derived; shift-amount width, not overridden
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; for shift, only b[SHW-1:0] is the shift amount
- op  in  2  0 add, 1 subtract, 2 arithmetic shift right, 3 multiply
- out_valid  out  1  one-cycle pulse: out and flags updated
- out  out  WIDTH  result
- cout  out  1  carry / not-borrow / last bit shifted out
- zero  out  1  out == 0
- neg  out  1  out[WIDTH-1]
- ovf  out  1  signed overflow (add/sub) or product truncation (mul)

## Operation
- States: IDLE, MUL. in_ready = 1 in IDLE and 0 in MUL.
- A request is accepted on a rising edge with in_valid && in_ready. While in_ready = 0, in_valid is ignored; there is no queueing.
- op 0: {cout, out} = a + b. ovf = sign(a) == sign(b) && sign(out) != sign(a).
- op 1: out = a + ~b + 1. cout = carry out (1 means a ≥ b unsigned). ovf = sign(a) != sign(b) && sign(out) != sign(a).
- op 2: out = $signed(a) >>> b[SHW-1:0]. cout = last bit shifted out, or 0 if the amount is 0. ovf = 0.
- op 3: a and b are captured into internal registers (product accumulator 2·WIDTH, multiplier, counter SHW+1 bits) and the unit enters MUL.
  - Each MUL cycle adds the shifted multiplicand when the current multiplier bit is 1, then shifts.
  - After WIDTH steps: out = product[WIDTH-1:0], ovf = |product[2·WIDTH-1:WIDTH], cout = 0. Return to IDLE.
- zero and neg are always derived from the new out value.
- out and flags are written together with out_valid and hold until the next result.
- Operands are unsigned except for the signed flags and the sign-filling shift. All arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State goes to IDLE, so in_ready = 1.
  - out_valid, out, cout, zero, neg, ovf are all 0.
  - Internal accumulator, multiplier and counter are cleared.
- op 0–2: latency 1. Result and out_valid = 1 appear after the accepting edge E.
  - in_ready stays 1, so back-to-back requests are accepted every cycle and give one result per cycle.
- op 3: result and out_valid appear after edge E+WIDTH.
  - in_ready = 0 in the WIDTH cycles following E.
  - The earliest next accept is edge E+WIDTH+1. The cycle where out_valid = 1 also has in_ready = 1.
- out_valid is never high for two consecutive cycles on a single request.
- Reset during MUL aborts the operation: no out_valid, outputs go to their reset values, and the unit is back in IDLE.
- Operand changes after acceptance have no effect on the operation in flight.

## Test plan
- WIDTH=8, add a=11 b=4 → one cycle later out=15, cout=0, ovf=0, out_valid a single-cycle pulse. Then add 255+1 → out=0, cout=1, zero=1. Then add 127+1 → out=128, ovf=1, neg=1.
- Sub 11−4 → out=7, cout=1. Sub 4−11 → out=249, cout=0, neg=1. Sub 128−1 → out=127, ovf=1.
- Shift 240 by 2 → out=252, cout=0, neg=1. Shift 0x81 by 1 → out=0xC0, cout=1. Shift with b=8: only b[2:0]=0 is used → out=a, cout=0.
- Mul 13×11 → out=143, ovf=0. out_valid exactly 8 cycles after acceptance; in_ready low for those 8 cycles; an add request held during MUL is not accepted until in_ready returns. Mul 16×16 → out=0, ovf=1, zero=1.
- Back-to-back: adds with a=1..4, b=1 on four consecutive cycles → out=2,3,4,5 on four consecutive cycles, out_valid high throughout.
- Assert rst_n low 3 cycles into a mul → outputs immediately 0 and in_ready=1, no out_valid pulse. A following add 11+4 → out=15 after 1 cycle.
